mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one unified memory port between instruction fetch and the load/store path of the RV32I core.
//  Grants one access at a time, holds the memory request stable until the memory acknowledges it,
//  and returns read data to the port that issued the request.
//  Drives the core-wide stall while any request is pending, and aborts hung accesses after a timeout.
// PARAMETERS
//  TIMEOUT   255  cycles of m_valid without m_ready before the access is aborted; 0 disables the timeout
//  CNT_W     16   width of the wait counter; TIMEOUT must be <= 2**CNT_W-1
// PORTS
//  clk          in   1   clock; all state updates on rising edge
//  rst_n        in   1   asynchronous active-low reset
//  if_req       in   1   fetch request; held high by the core until if_done
//  if_addr      in   32  fetch address (PC)
//  if_rdata     out  32  fetched instruction; valid while if_done=1
//  if_done      out  1   one-cycle pulse: fetch complete
//  d_req        in   1   data request; held high by the core until d_done
//  d_we         in   1   1=store, 0=load (memRW)
//  d_addr       in   32  data address (ALU result)
//  d_wdata      in   32  store data
//  d_size       in   2   store size code (storesize), passed through unchanged
//  d_rdata      out  32  load data; valid while d_done=1
//  d_done       out  1   one-cycle pulse: data access complete
//  m_valid      out  1   memory request valid
//  m_we         out  1   memory write enable
//  m_addr       out  32  memory address
//  m_wdata      out  32  memory write data
//  m_size       out  2   memory store size; 0 on fetches
//  m_rdata      in   32  memory read data; sampled when m_ready=1
//  m_ready      in   1   memory acknowledge; completes the current access
//  stall        out  1   freeze PC and pipeline registers
//  timeout_err  out  1   sticky flag: an access was aborted
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE; every registered output, the latches and the counter clear to 0.
//    m_valid drops immediately and any in-flight access is abandoned without a done pulse.
//  - States: IDLE, FETCH, DATA.
//    IDLE->DATA   if d_req is eligible and (if_req is not eligible, or last_grant=FETCH).
//    IDLE->FETCH  if if_req is eligible and (d_req is not eligible, or last_grant=DATA).
//    last_grant resets to FETCH, so data wins the first tie. After that, ties alternate to prevent starvation.
//  - Eligible: a req is eligible only if the same port's done is not asserted in that cycle.
//    The done cycle therefore never causes a regrant of the finished request.
//  - On the grant edge the port's addr/wdata/we/size are latched into the m_* registers.
//    FETCH uses m_we=0 and m_size=0. m_valid=1 from the next cycle, and the m_* outputs stay stable until m_ready.
//  - FETCH with m_ready=1: if_rdata<=m_rdata, if_done<=1 for exactly one cycle, m_valid<=0, state->IDLE.
//    DATA with m_ready=1 is identical but drives d_rdata/d_done; on a store d_rdata<=0.
//  - Latency: minimum 3 cycles from req to done when memory returns m_ready in the first cycle of m_valid.
//    No back-to-back grant occurs without one IDLE cycle between them.
//  - rdata outputs hold their value after done until the next completion on the same port.
//  - Timeout (TIMEOUT>0): the counter clears on grant and increments each FETCH/DATA cycle with m_ready=0.
//    When the counter reaches TIMEOUT: abort, pulse that port's done with rdata=0, set timeout_err, go to IDLE.
//    If m_ready=1 arrives in that same cycle, it is a normal completion.
//  - timeout_err clears only on reset.
//  - stall = (if_req & ~if_done) | (d_req & ~d_done), combinational.
//  - m_ready while in IDLE is ignored. Req changes after grant do not affect the access in flight.
// TESTING
//  - Single fetch: if_req=1, if_addr=0x100, m_ready on the 1st m_valid cycle with m_rdata=0x00500093.
//    -> m_addr=0x100, m_we=0, if_done pulses once, if_rdata=0x00500093, stall drops in the done cycle.
//  - Tie, then alternation: if_req and d_req rise together on a store to 0x2000, wdata 0xDEADBEEF, size 2.
//    -> DATA granted first with m_we=1 and m_size=2; FETCH is granted next, after one IDLE cycle.
//  - Wait states: load from 0x40 with m_ready delayed 5 cycles, m_rdata=0x12345678.
//    -> m_* stay constant for all 6 m_valid cycles; d_rdata=0x12345678; stall stays high throughout.
//  - Timeout with TIMEOUT=4: fetch issued and m_ready never asserted.
//    -> abort after 4 waiting cycles; if_done=1 with if_rdata=0; timeout_err=1 until rst_n=0.
//  - Reset mid-access: rst_n=0 during the 2nd DATA wait cycle.
//    -> m_valid=0 asynchronously, no d_done, state IDLE; after release, the first tie is granted to DATA.
//  - No regrant: hold d_req for one cycle after d_done.
//    -> exactly one memory access; the extra req is granted only if it is still high after the done cycle.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one unified memory port between instruction fetch and the
//   load/store path. One access is in flight at a time; the m_* request is
//   latched on the grant edge and held until m_ready (or a timeout abort).
//   Read data is returned to the requesting port with a one-cycle done pulse.
// Ports
//   clk, rst_n                      clock, async active-low reset
//   if_req/if_addr                  fetch request (held until if_done)
//   if_rdata/if_done                fetched word, one-cycle completion pulse
//   d_req/d_we/d_addr/d_wdata/d_size data request (held until d_done)
//   d_rdata/d_done                  load data (0 on stores/aborts), completion pulse
//   m_valid/m_we/m_addr/m_wdata/m_size  memory request (stable until m_ready)
//   m_rdata/m_ready                 memory response
//   stall                           core-wide freeze while a request is pending
//   timeout_err                     sticky: an access was aborted
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_done,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [1:0]  d_size,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        m_valid,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [1:0]  m_size,
  input  logic [31:0] m_rdata,
  input  logic        m_ready,
  output logic        stall,
  output logic        timeout_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;

  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

  logic [1:0]       state;
  logic             last_data;  // 1: most recent grant went to DATA
  logic [CNT_W-1:0] cnt;
  logic             if_elig;
  logic             d_elig;
  logic             grant_d;
  logic             grant_f;
  logic             timed_out;

  // A port whose done is showing this cycle is not eligible, so the
  // request the core is still holding is never granted a second time.
  assign if_elig = if_req & ~if_done;
  assign d_elig  = d_req  & ~d_done;

  // Ties go to the port that was not served last; reset value favours DATA.
  assign grant_d = d_elig  & (~if_elig | ~last_data);
  assign grant_f = if_elig & (~d_elig  |  last_data);

  assign timed_out = (TIMEOUT != 0) && (cnt == TO_VAL);

  assign stall = (if_req & ~if_done) | (d_req & ~d_done);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      last_data   <= 1'b0;
      cnt         <= '0;
      m_valid     <= 1'b0;
      m_we        <= 1'b0;
      m_addr      <= '0;
      m_wdata     <= '0;
      m_size      <= '0;
      if_rdata    <= '0;
      if_done     <= 1'b0;
      d_rdata     <= '0;
      d_done      <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if_done <= 1'b0;
      d_done  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant_d) begin
            state     <= S_DATA;
            last_data <= 1'b1;
            cnt       <= '0;
            m_valid   <= 1'b1;
            m_we      <= d_we;
            m_addr    <= d_addr;
            m_wdata   <= d_wdata;
            m_size    <= d_size;
          end else if (grant_f) begin
            state     <= S_FETCH;
            last_data <= 1'b0;
            cnt       <= '0;
            m_valid   <= 1'b1;
            m_we      <= 1'b0;
            m_addr    <= if_addr;
            m_wdata   <= '0;
            m_size    <= '0;
          end
        end
        S_FETCH, S_DATA: begin
          // m_ready wins over a timeout landing in the same cycle.
          if (m_ready || timed_out) begin
            state   <= S_IDLE;
            m_valid <= 1'b0;
            if (state == S_FETCH) begin
              if_done  <= 1'b1;
              if_rdata <= m_ready ? m_rdata : '0;
            end else begin
              d_done  <= 1'b1;
              d_rdata <= (m_ready && !m_we) ? m_rdata : '0;
            end
            if (!m_ready) begin
              timeout_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state   <= S_IDLE;
          m_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios plus randomized traffic,
// with a scoreboard of expected completions and a reference model of the
// arbitration, latching, timeout and done/rdata rules.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int unsigned TO = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [1:0]  d_size = '0;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        m_valid;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [1:0]  m_size;
  logic [31:0] m_rdata;
  logic        m_ready;
  logic        stall;
  logic        timeout_err;

  always #5 clk = ~clk;

  mem_port_arbiter #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
    .d_rdata(d_rdata), .d_done(d_done),
    .m_valid(m_valid), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_size(m_size),
    .m_rdata(m_rdata), .m_ready(m_ready),
    .stall(stall), .timeout_err(timeout_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- memory responder ----------------
  bit          fixed_mode = 1'b1;
  int          fix_dly = 0;
  logic [31:0] fix_data = '0;
  bit          noise = 1'b0;

  initial begin
    bit in_acc;
    int wcnt;
    int dly;
    int r;
    in_acc  = 1'b0;
    wcnt    = 0;
    dly     = 0;
    m_ready = 1'b0;
    m_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (m_valid) begin
        if (!in_acc) begin
          in_acc = 1'b1;
          wcnt   = 0;
          if (fixed_mode) dly = fix_dly;
          else begin
            r   = $urandom_range(0, 9);
            dly = (r < 7) ? r : 1000;
          end
        end
        m_ready = (wcnt == dly);
        m_rdata = fixed_mode ? fix_data : $urandom;
        wcnt++;
      end else begin
        in_acc  = 1'b0;
        m_ready = noise && ($urandom_range(0, 3) == 0);
        m_rdata = $urandom;
      end
    end
  end

  // ---------------- reference model + scoreboard monitor ----------------
  typedef struct {
    logic        port;   // 1 = data
    logic [31:0] data;
    logic        abort;
    int          due;
  } done_t;

  done_t sb[$];

  int          cyc = 0;
  int          n_access = 0;
  logic        p_ef = 1'b0, p_ed = 1'b0, p_idle = 1'b1;
  logic        last_d = 1'b0;
  logic        busy = 1'b0;
  logic        cur_d = 1'b0;
  logic        e_we = 1'b0;
  logic [31:0] e_addr = '0, e_wdata = '0;
  logic [1:0]  e_size = '0;
  logic [31:0] pf_addr = '0, pd_addr = '0, pd_wdata = '0;
  logic        pd_we = 1'b0;
  logic [1:0]  pd_size = '0;
  int          wait_n = 0;
  logic [31:0] exp_if_rdata = '0, exp_d_rdata = '0;
  logic        exp_terr = 1'b0;
  logic        efd, edd;
  done_t       ent;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_m_valid", {31'b0, m_valid}, 32'd0);
      chk("reset_if_done", {31'b0, if_done}, 32'd0);
      chk("reset_d_done", {31'b0, d_done}, 32'd0);
      chk("reset_timeout_err", {31'b0, timeout_err}, 32'd0);
      sb.delete();
      p_ef = 1'b0; p_ed = 1'b0; p_idle = 1'b1; last_d = 1'b0; busy = 1'b0;
      exp_if_rdata = '0; exp_d_rdata = '0; exp_terr = 1'b0;
    end else begin
      cyc++;
      efd = 1'b0;
      edd = 1'b0;
      if (sb.size() > 0 && sb[0].due == cyc) begin
        if (sb[0].port) begin edd = 1'b1; exp_d_rdata = sb[0].data; end
        else begin efd = 1'b1; exp_if_rdata = sb[0].data; end
        if (sb[0].abort) exp_terr = 1'b1;
        void'(sb.pop_front());
      end
      chk("if_done", {31'b0, if_done}, {31'b0, efd});
      chk("d_done", {31'b0, d_done}, {31'b0, edd});
      chk("if_rdata", if_rdata, exp_if_rdata);
      chk("d_rdata", d_rdata, exp_d_rdata);
      chk("stall", {31'b0, stall}, {31'b0, (if_req & ~efd) | (d_req & ~edd)});
      chk("timeout_err", {31'b0, timeout_err}, {31'b0, exp_terr});

      // a grant only follows an idle cycle with some eligible request
      if (!busy && p_idle && (p_ef || p_ed)) begin
        cur_d   = p_ed && (!p_ef || !last_d);
        last_d  = cur_d;
        busy    = 1'b1;
        wait_n  = 0;
        n_access++;
        e_we    = cur_d ? pd_we : 1'b0;
        e_addr  = cur_d ? pd_addr : pf_addr;
        e_size  = cur_d ? pd_size : 2'd0;
        e_wdata = pd_wdata;
      end
      chk("m_valid", {31'b0, m_valid}, {31'b0, busy});
      p_idle = !busy;
      if (busy) begin
        chk("m_we", {31'b0, m_we}, {31'b0, e_we});
        chk("m_addr", m_addr, e_addr);
        chk("m_size", {30'b0, m_size}, {30'b0, e_size});
        if (cur_d && e_we) chk("m_wdata", m_wdata, e_wdata);
        if (m_ready) begin
          ent.port  = cur_d;
          ent.data  = (cur_d && e_we) ? 32'd0 : m_rdata;
          ent.abort = 1'b0;
          ent.due   = cyc + 1;
          sb.push_back(ent);
          busy = 1'b0;
        end else if (wait_n == int'(TO)) begin
          ent.port  = cur_d;
          ent.data  = 32'd0;
          ent.abort = 1'b1;
          ent.due   = cyc + 1;
          sb.push_back(ent);
          busy = 1'b0;
        end else begin
          wait_n++;
        end
      end
      p_ef     = if_req & ~efd;
      p_ed     = d_req & ~edd;
      pf_addr  = if_addr;
      pd_addr  = d_addr;
      pd_wdata = d_wdata;
      pd_we    = d_we;
      pd_size  = d_size;
    end
  end

  // done as seen by the core in the cycle just ended
  logic f_seen = 1'b0, d_seen = 1'b0;
  always @(negedge clk) begin
    f_seen = if_done;
    d_seen = d_done;
  end

  // ---------------- core-side driver ----------------
  task automatic step(input bit rnd);
    @(posedge clk);
    #1;
    if (if_req && f_seen) begin
      if (rnd && $urandom_range(0, 1) == 1) if_addr = $urandom & 32'hFFFF_FFFC;
      else if_req = 1'b0;
    end else if (if_req && rnd && $urandom_range(0, 7) == 0) begin
      if_addr = $urandom & 32'hFFFF_FFFC;
    end else if (!if_req && rnd && $urandom_range(0, 2) == 0) begin
      if_req  = 1'b1;
      if_addr = $urandom & 32'hFFFF_FFFC;
    end
    if (d_req && d_seen) begin
      if (rnd && $urandom_range(0, 1) == 1) begin
        d_we = 1'($urandom); d_addr = $urandom; d_wdata = $urandom; d_size = 2'($urandom);
      end else d_req = 1'b0;
    end else if (d_req && rnd && $urandom_range(0, 7) == 0) begin
      d_addr = $urandom; d_wdata = $urandom; d_we = 1'($urandom);
    end else if (!d_req && rnd && $urandom_range(0, 2) == 0) begin
      d_req = 1'b1;
      d_we = 1'($urandom); d_addr = $urandom; d_wdata = $urandom; d_size = 2'($urandom);
    end
  endtask

  task automatic run_idle(input string name);
    int k;
    k = 0;
    while ((if_req || d_req) && k < 200) begin
      step(1'b0);
      k++;
    end
    chk({name, "_drained"}, {31'b0, if_req | d_req}, 32'd0);
    repeat (2) step(1'b0);
  endtask

  task automatic wait_done(input bit dport, input string name, output int cycles);
    cycles = 0;
    forever begin
      @(negedge clk);
      cycles++;
      if ((dport ? d_done : if_done) === 1'b1) break;
      if (cycles >= 50) break;
    end
    chk({name, "_done_seen"}, {31'b0, dport ? d_done : if_done}, 32'd1);
  endtask

  initial begin
    int n;
    int a0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) step(1'b0);

    // single fetch, memory ready in the first valid cycle
    fixed_mode = 1'b1; fix_dly = 0; fix_data = 32'h0050_0093;
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h100;
    wait_done(1'b0, "fetch1", n);
    chk("fetch1_latency", n, 32'd3);
    chk("fetch1_rdata", if_rdata, 32'h0050_0093);
    chk("fetch1_stall", {31'b0, stall}, 32'd0);
    run_idle("fetch1");

    // simultaneous store and fetch: data first, fetch after an idle cycle
    fix_data = 32'hCAFE_0001;
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h300;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF; d_size = 2'd2;
    @(negedge clk);
    @(negedge clk);
    chk("tie_m_we", {31'b0, m_we}, 32'd1);
    chk("tie_m_size", {30'b0, m_size}, 32'd2);
    chk("tie_m_addr", m_addr, 32'h2000);
    run_idle("tie");

    // load with five wait states; also lands exactly on the timeout count
    fix_dly = 5; fix_data = 32'h1234_5678;
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40; d_size = 2'd0;
    wait_done(1'b1, "wait5", n);
    chk("wait5_latency", n, 32'd8);
    chk("wait5_rdata", d_rdata, 32'h1234_5678);
    chk("wait5_no_err", {31'b0, timeout_err}, 32'd0);
    run_idle("wait5");

    // hung fetch is aborted
    fix_dly = 1000;
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h500;
    wait_done(1'b0, "timeout", n);
    chk("timeout_latency", n, 32'd8);
    chk("timeout_rdata", if_rdata, 32'd0);
    chk("timeout_err_set", {31'b0, timeout_err}, 32'd1);
    run_idle("timeout");
    chk("timeout_err_sticky", {31'b0, timeout_err}, 32'd1);

    // reset during the second wait cycle of a load
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("async_m_valid", {31'b0, m_valid}, 32'd0);
    chk("async_d_done", {31'b0, d_done}, 32'd0);
    chk("async_timeout_err", {31'b0, timeout_err}, 32'd0);
    if_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    fix_dly = 0;
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h310;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2200;
    @(negedge clk);
    @(negedge clk);
    chk("tie_after_reset", m_addr, 32'h2200);
    run_idle("post_reset");

    // request held through its done cycle must not be regranted
    a0 = n_access;
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h90;
    wait_done(1'b1, "noregrant", n);
    run_idle("noregrant");
    chk("noregrant_accesses", n_access - a0, 32'd1);

    // randomized traffic with idle-time m_ready noise
    fixed_mode = 1'b0;
    noise = 1'b1;
    repeat (3000) step(1'b1);
    run_idle("random");
    repeat (3) step(1'b0);
    chk("scoreboard_empty", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
